// File: rtl/divmod_pkg.sv
// Shared defaults for the pipelined divider.
// The stage-payload struct depends on WIDTH and TAG_W, so it is declared
// inside pipelined_divmod from its own localparams rather than here.
package divmod_pkg;

  localparam int DIVMOD_DEF_WIDTH = 32;
  localparam int DIVMOD_DEF_TAG_W = 4;

endpackage

// File: rtl/divmod_stage.sv
// One restoring-division step plus its pipeline register.
// The stage shifts the next dividend bit into the partial remainder, tries to
// subtract the divisor magnitude, and shifts the resulting quotient bit into
// the low end of quot, which also holds the not-yet-consumed dividend bits.
// While en is low every register holds. Only the valid bit is reset.
module divmod_stage
  import divmod_pkg::*;
#(
  parameter int WIDTH  = DIVMOD_DEF_WIDTH,
  parameter int SIDE_W = DIVMOD_DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              valid_i,
  input  logic [WIDTH-1:0]  rem_i,
  input  logic [WIDTH-1:0]  quot_i,
  input  logic [WIDTH-1:0]  dmag_i,
  input  logic [SIDE_W-1:0] side_i,
  output logic              valid_o,
  output logic [WIDTH-1:0]  rem_o,
  output logic [WIDTH-1:0]  quot_o,
  output logic [WIDTH-1:0]  dmag_o,
  output logic [SIDE_W-1:0] side_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             qbit_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quot_d;
  // Bit WIDTH of a non-negative trial is always zero because rem < divisor.
  logic             trial_unused;

  logic              valid_q;
  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  quot_q;
  logic [WIDTH-1:0]  dmag_q;
  logic [SIDE_W-1:0] side_q;

  assign shifted      = {rem_i, quot_i[WIDTH-1]};
  assign trial        = {1'b0, shifted} - {2'b00, dmag_i};
  assign trial_unused = trial[WIDTH];

  // Compare/subtract step: keep the difference when it is non-negative.
  always_comb begin
    qbit_d = ~trial[WIDTH+1];
    rem_d  = qbit_d ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quot_d = {quot_i[WIDTH-2:0], qbit_d};
  end

  // Valid bit: cleared by reset, otherwise shifts with the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (en) begin
      valid_q <= valid_i;
    end
  end

  // Payload registers: no reset needed, they only matter when valid.
  always_ff @(posedge clk) begin
    if (en) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dmag_q <= dmag_i;
      side_q <= side_i;
    end
  end

  assign valid_o = valid_q;
  assign rem_o   = rem_q;
  assign quot_o  = quot_q;
  assign dmag_o  = dmag_q;
  assign side_o  = side_q;

endmodule

// File: rtl/pipelined_divmod.sv
// Fully pipelined integer divider: quotient and remainder, WIDTH stages,
// one operation per cycle, latency WIDTH cycles, opaque tag carried along.
// Optional feature: define DIVMOD_DIV0_FLAG_EN to add the out_div0 port and
// carry a per-operation divide-by-zero flag down the pipe.
//
// Handshake: an operation transfers on in_valid & in_ready, a result on
// out_valid & out_ready. The whole pipe advances when (!out_valid | out_ready);
// in_ready equals that advance term and never looks at in_valid. Bubbles
// travel as invalid stages and order is always preserved.
module pipelined_divmod
  import divmod_pkg::*;
#(
  parameter int WIDTH  = DIVMOD_DEF_WIDTH,
  parameter int SIGNED = 0,
  parameter int TAG_W  = DIVMOD_DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic [TAG_W-1:0] out_tag
`ifdef DIVMOD_DIV0_FLAG_EN
  ,
  output logic             out_div0
`endif
);

  localparam bit IS_SIGNED = (SIGNED != 0);

  typedef struct packed {
    logic             neg_q;
    logic             neg_r;
`ifdef DIVMOD_DIV0_FLAG_EN
    logic             div0;
`endif
    logic [TAG_W-1:0] tag;
  } side_t;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] dmag;
    side_t            side;
  } stage_t;

  localparam int SIDE_W = $bits(side_t);

  logic             advance;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH:0]   a_wide;
  logic [WIDTH:0]   b_wide;
  logic [WIDTH:0]   a_mag_w;
  logic [WIDTH:0]   b_mag_w;
  // Magnitudes fit in WIDTH bits, even for MIN_INT; the top bit is always 0.
  logic             mag_unused;
  stage_t           ent_s;
  stage_t           last_s;
  logic             last_div0;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Stage chain: index 0 is the entry payload, index WIDTH the last register.
  logic [WIDTH:0]   v_c;
  logic [WIDTH-1:0] rem_c  [WIDTH+1];
  logic [WIDTH-1:0] quot_c [WIDTH+1];
  logic [WIDTH-1:0] dmag_c [WIDTH+1];
  logic [SIDE_W-1:0] side_c [WIDTH+1];

  assign advance  = ~last_s.valid | out_ready;
  assign in_ready = advance;

  // Entry: take magnitudes in WIDTH+1-bit arithmetic and record sign fix-ups.
  always_comb begin
    a_neg   = IS_SIGNED & in_a[WIDTH-1];
    b_neg   = IS_SIGNED & in_b[WIDTH-1];
    a_wide  = {a_neg, in_a};
    b_wide  = {b_neg, in_b};
    a_mag_w = a_neg ? -a_wide : a_wide;
    b_mag_w = b_neg ? -b_wide : b_wide;
    ent_s            = '0;
    ent_s.valid      = in_valid;
    ent_s.rem        = '0;
    ent_s.quot       = a_mag_w[WIDTH-1:0];
    ent_s.dmag       = b_mag_w[WIDTH-1:0];
    ent_s.side.neg_q = a_neg ^ b_neg;
    ent_s.side.neg_r = a_neg;
`ifdef DIVMOD_DIV0_FLAG_EN
    ent_s.side.div0  = (in_b == '0);
`endif
    ent_s.side.tag   = in_tag;
  end

  assign mag_unused = a_mag_w[WIDTH] ^ b_mag_w[WIDTH];

  assign v_c[0]    = ent_s.valid;
  assign rem_c[0]  = ent_s.rem;
  assign quot_c[0] = ent_s.quot;
  assign dmag_c[0] = ent_s.dmag;
  assign side_c[0] = ent_s.side;

  for (genvar k = 0; k < WIDTH; k++) begin : g_stage
    divmod_stage #(
      .WIDTH  (WIDTH),
      .SIDE_W (SIDE_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (advance),
      .valid_i (v_c[k]),
      .rem_i   (rem_c[k]),
      .quot_i  (quot_c[k]),
      .dmag_i  (dmag_c[k]),
      .side_i  (side_c[k]),
      .valid_o (v_c[k+1]),
      .rem_o   (rem_c[k+1]),
      .quot_o  (quot_c[k+1]),
      .dmag_o  (dmag_c[k+1]),
      .side_o  (side_c[k+1])
    );
  end

  assign last_s.valid = v_c[WIDTH];
  assign last_s.rem   = rem_c[WIDTH];
  assign last_s.quot  = quot_c[WIDTH];
  assign last_s.dmag  = dmag_c[WIDTH];
  assign last_s.side  = side_c[WIDTH];

  // Result fix-up on the last register. With a zero divisor the remainder
  // path already holds |a|, so the sign fix-up restores a exactly; only the
  // quotient needs forcing to all ones.
  always_comb begin
    last_div0 = (last_s.dmag == '0);
    quot_fix  = last_s.side.neg_q ? -last_s.quot : last_s.quot;
    rem_fix   = last_s.side.neg_r ? -last_s.rem : last_s.rem;
    if (last_div0) begin
      quot_fix = '1;
    end
  end

  assign out_valid = last_s.valid;
  assign out_quot  = last_s.valid ? quot_fix : '0;
  assign out_rem   = last_s.valid ? rem_fix : '0;
  assign out_tag   = last_s.valid ? last_s.side.tag : '0;
`ifdef DIVMOD_DIV0_FLAG_EN
  assign out_div0  = last_s.valid & last_s.side.div0;
`endif

endmodule

// File: tb/tb_pipelined_divmod.sv
// Bench for pipelined_divmod: one unsigned and one signed instance share the
// same input stream and backpressure; each has its own expected queue fed by
// an arithmetic reference model.
module tb_pipelined_divmod;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int EW = 1 + TW + 2 * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;
  logic          out_ready;

  logic          u_in_ready, u_out_valid;
  logic [W-1:0]  u_out_quot, u_out_rem;
  logic [TW-1:0] u_out_tag;
  logic          s_in_ready, s_out_valid;
  logic [W-1:0]  s_out_quot, s_out_rem;
  logic [TW-1:0] s_out_tag;
`ifdef DIVMOD_DIV0_FLAG_EN
  logic          u_out_div0, s_out_div0;
`endif

  pipelined_divmod #(.WIDTH(W), .SIGNED(0), .TAG_W(TW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (u_in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (u_out_valid),
    .out_ready (out_ready),
    .out_quot  (u_out_quot),
    .out_rem   (u_out_rem),
    .out_tag   (u_out_tag)
`ifdef DIVMOD_DIV0_FLAG_EN
    ,
    .out_div0  (u_out_div0)
`endif
  );

  pipelined_divmod #(.WIDTH(W), .SIGNED(1), .TAG_W(TW)) s_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_quot  (s_out_quot),
    .out_rem   (s_out_rem),
    .out_tag   (s_out_tag)
`ifdef DIVMOD_DIV0_FLAG_EN
    ,
    .out_div0  (s_out_div0)
`endif
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected entry layout: {div0, tag, quotient, remainder}.
  function automatic logic [EW-1:0] ref_unsigned(input logic [W-1:0] a, input logic [W-1:0] b,
                                                  input logic [TW-1:0] t);
    logic [W-1:0] q, r;
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {(b == 0), t, q, r};
  endfunction

  function automatic logic [EW-1:0] ref_signed(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [TW-1:0] t);
    longint sa, sb, lq, lr;
    logic [63:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 0) begin
      lq = -1;
      lr = sa;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
    end
    uq = lq;
    ur = lr;
    return {(b == 0), t, uq[W-1:0], ur[W-1:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_u[$];
  logic [EW-1:0] exp_s[$];
  logic [EW-1:0] mon_u, mon_s;
  int out_cnt_u = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_u.delete();
      exp_s.delete();
    end else begin
      if (u_out_valid && out_ready) begin
        out_cnt_u++;
        if (exp_u.size() == 0) begin
          check_eq("u_unexpected_out", {31'd0, u_out_valid}, 0);
        end else begin
          mon_u = exp_u.pop_front();
          check_eq("u_quot", u_out_quot, mon_u[2*W-1:W]);
          check_eq("u_rem", u_out_rem, mon_u[W-1:0]);
          check_eq("u_tag", {28'd0, u_out_tag}, {28'd0, mon_u[2*W+TW-1:2*W]});
`ifdef DIVMOD_DIV0_FLAG_EN
          check_eq("u_div0", {31'd0, u_out_div0}, {31'd0, mon_u[EW-1]});
`endif
        end
      end
      if (s_out_valid && out_ready) begin
        if (exp_s.size() == 0) begin
          check_eq("s_unexpected_out", {31'd0, s_out_valid}, 0);
        end else begin
          mon_s = exp_s.pop_front();
          check_eq("s_quot", s_out_quot, mon_s[2*W-1:W]);
          check_eq("s_rem", s_out_rem, mon_s[W-1:0]);
          check_eq("s_tag", {28'd0, s_out_tag}, {28'd0, mon_s[2*W+TW-1:2*W]});
`ifdef DIVMOD_DIV0_FLAG_EN
          check_eq("s_div0", {31'd0, s_out_div0}, {31'd0, mon_s[EW-1]});
`endif
        end
      end
      if (in_valid && u_in_ready) exp_u.push_back(ref_unsigned(in_a, in_b, in_tag));
      if (in_valid && s_in_ready) exp_s.push_back(ref_signed(in_a, in_b, in_tag));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'($urandom_range(1, 15));
      2: return '1;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t);
    int n;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!u_in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check_eq("send_timeout", {31'd0, u_in_ready}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Single op into an empty pipe with out_ready=1: checks latency and results.
  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t,
                         input logic [W-1:0] uq, input logic [W-1:0] ur,
                         input logic [W-1:0] sq, input logic [W-1:0] sr);
    int n;
    send(a, b, t);
    n = 1;
    while (!u_out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("latency", n, W);
    check_eq("lat_s_valid", {31'd0, s_out_valid}, 1);
    check_eq("dir_u_quot", u_out_quot, uq);
    check_eq("dir_u_rem", u_out_rem, ur);
    check_eq("dir_u_tag", {28'd0, u_out_tag}, {28'd0, t});
    check_eq("dir_s_quot", s_out_quot, sq);
    check_eq("dir_s_rem", s_out_rem, sr);
    check_eq("dir_s_tag", {28'd0, s_out_tag}, {28'd0, t});
`ifdef DIVMOD_DIV0_FLAG_EN
    check_eq("dir_u_div0", {31'd0, u_out_div0}, {31'd0, (b == 0)});
    check_eq("dir_s_div0", {31'd0, s_out_div0}, {31'd0, (b == 0)});
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_u.size() != 0 || exp_s.size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_u", exp_u.size(), 0);
    check_eq("drain_s", exp_s.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  logic bp_done;
  int   cnt0;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    bp_done   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hold_u_valid", {31'd0, u_out_valid}, 0);
    check_eq("rst_hold_s_valid", {31'd0, s_out_valid}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_u_valid", {31'd0, u_out_valid}, 0);
    check_eq("rst_u_in_ready", {31'd0, u_in_ready}, 1);
    check_eq("rst_u_quot", u_out_quot, 0);
    check_eq("rst_u_rem", u_out_rem, 0);
    check_eq("rst_u_tag", {28'd0, u_out_tag}, 0);
    check_eq("rst_s_valid", {31'd0, s_out_valid}, 0);
    check_eq("rst_s_in_ready", {31'd0, s_in_ready}, 1);
    @(posedge clk);
    #1;

    // Directed cases: hand-derived expectations for both signednesses.
    run_one(32'd100,       32'd7,         4'd3,  32'd14,        32'd2,         32'd14,        32'd2);
    run_one(32'hFFFF_FFFF, 32'd1,         4'd5,  32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'd0);
    run_one(32'hFFFF_FFF9, 32'd2,         4'd6,  32'h7FFF_FFFC, 32'd1,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_one(32'd7,         32'hFFFF_FFFE, 4'd7,  32'd0,         32'd7,         32'hFFFF_FFFD, 32'd1);
    run_one(32'h8000_0000, 32'hFFFF_FFFF, 4'd8,  32'd0,         32'h8000_0000, 32'h8000_0000, 32'd0);
    run_one(32'h0000_1234, 32'd0,         4'hA,  32'hFFFF_FFFF, 32'h1234,      32'hFFFF_FFFF, 32'h1234);

    // 64 back-to-back ops: results must come out on 64 consecutive cycles.
    fork
      begin
        for (int i = 0; i < 64; i++) send(rand_opnd(), rand_opnd(), TW'($urandom_range(0, 15)));
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!u_out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        check_eq("b2b_start", {31'd0, u_out_valid}, 1);
        n = 0;
        while (u_out_valid && n < 200) begin
          n++;
          @(negedge clk);
        end
        check_eq("b2b_run_len", n, 64);
      end
    join
    @(posedge clk);
    #1;
    wait_drain();

    // Full pipe held for 10 cycles by out_ready=0.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(rand_opnd(), rand_opnd(), TW'($urandom_range(0, 15)));
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!u_out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        check_eq("stall_fill", {31'd0, u_out_valid}, 1);
        repeat (10) begin
          check_eq("stall_in_ready", {31'd0, u_in_ready}, 0);
          check_eq("stall_valid", {31'd0, u_out_valid}, 1);
          check_eq("stall_quot", u_out_quot, exp_u[0][2*W-1:W]);
          check_eq("stall_rem", u_out_rem, exp_u[0][W-1:0]);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Random bubbles and random backpressure.
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rand_opnd(), rand_opnd(), TW'($urandom_range(0, 15)));
        end
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with 20 ops in flight; an op offered during reset is ignored.
    for (int i = 0; i < 20; i++) send(rand_opnd(), rand_opnd(), TW'($urandom_range(0, 15)));
    rst      = 1'b1;
    in_valid = 1'b1;
    in_a     = 32'd5;
    in_b     = 32'd1;
    in_tag   = 4'd9;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check_eq("midrst_u_valid", {31'd0, u_out_valid}, 0);
    check_eq("midrst_s_valid", {31'd0, s_out_valid}, 0);
    cnt0 = out_cnt_u;
    run_one(32'd1000, 32'd33, 4'hC, 32'd30, 32'd10, 32'd30, 32'd10);
    repeat (40) @(posedge clk);
    #1;
    check_eq("midrst_out_count", out_cnt_u - cnt0, 1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
